// File: rtl/simd_inst_issuer.sv
// Warp-level instruction sequencer: latches one warp descriptor and issues pc 0..n-1 beats over rdy/ack.
// Optional perf counters (stall / warp) are built only when SIMD_ISSUE_PERF_EN is defined.
module simd_inst_issuer #(
   parameter int N_INST   = 16,
   parameter int INST_BW  = $clog2(N_INST + 1),
   parameter int DIM      = 2,
   parameter int WBW      = 16,
   parameter int MAX_WARP = 16,
   parameter int WID_BW   = $clog2(MAX_WARP)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     warp_rdy,
   output logic                     warp_ack,
   input  logic [WID_BW-1:0]        i_wid,
   input  logic [DIM-1:0][WBW-1:0]  i_bofs,
   input  logic [DIM-1:0][WBW-1:0]  i_aofs,
   input  logic [INST_BW-1:0]       i_n_inst,
   output logic                     inst_rdy,
   input  logic                     inst_ack,
   output logic [INST_BW-1:0]       o_pc,
   output logic [WID_BW-1:0]        o_wid,
   output logic [DIM-1:0][WBW-1:0]  o_bofs,
   output logic [DIM-1:0][WBW-1:0]  o_aofs,
   output logic                     o_last,
   output logic                     o_idle,
   output logic [31:0]              o_stall_cnt,
   output logic [31:0]              o_warp_cnt
);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   localparam logic [INST_BW-1:0] N_MAX = INST_BW'(N_INST);

   state_t                    state_reg, state_next;
   logic [INST_BW-1:0]        n_eff, n_reg, pc_reg, pc_next;
   logic [WID_BW-1:0]         wid_reg;
   logic [DIM-1:0][WBW-1:0]   bofs_reg, aofs_reg;
   logic                      load, last;

   assign n_eff = (i_n_inst > N_MAX) ? N_MAX : i_n_inst;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A new descriptor may only be taken when idle or on the ack of the final beat.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      load       = 1'b0;
      warp_ack   = 1'b0;
      inst_rdy   = 1'b0;
      last       = 1'b0;
      case (state_reg)
         IDLE: begin
            warp_ack = warp_rdy;
            if (warp_rdy && (n_eff != '0)) begin
               load       = 1'b1;
               pc_next    = '0;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            inst_rdy = 1'b1;
            last     = (pc_reg == (n_reg - INST_BW'(1)));
            if (inst_ack) begin
               if (!last) begin
                  pc_next = pc_reg + INST_BW'(1);
               end else if (warp_rdy) begin
                  warp_ack = 1'b1;
                  if (n_eff != '0) begin
                     load    = 1'b1;
                     pc_next = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pc_reg  <= '0;
         n_reg   <= '0;
         wid_reg <= '0;
      end else begin
         pc_reg <= pc_next;
         if (load) begin
            n_reg   <= n_eff;
            wid_reg <= i_wid;
         end
      end
   end

   for (genvar gi = 0; gi < DIM; gi++) begin : g_ofs
      always_ff @(posedge i_clk or negedge i_rst) begin
         if (!i_rst) begin
            bofs_reg[gi] <= '0;
            aofs_reg[gi] <= '0;
         end else if (load) begin
            bofs_reg[gi] <= i_bofs[gi];
            aofs_reg[gi] <= i_aofs[gi];
         end
      end
   end

   assign o_pc   = pc_reg;
   assign o_wid  = wid_reg;
   assign o_bofs = bofs_reg;
   assign o_aofs = aofs_reg;
   assign o_last = last;
   assign o_idle = (state_reg == IDLE);

`ifdef SIMD_ISSUE_PERF_EN
   logic [31:0] stall_cnt_reg, warp_cnt_reg;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         stall_cnt_reg <= '0;
         warp_cnt_reg  <= '0;
      end else begin
         if (inst_rdy && !inst_ack && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (load && (warp_cnt_reg != 32'hFFFF_FFFF))
            warp_cnt_reg <= warp_cnt_reg + 32'd1;
      end
   end

   assign o_stall_cnt = stall_cnt_reg;
   assign o_warp_cnt  = warp_cnt_reg;
`else
   assign o_stall_cnt = 32'd0;
   assign o_warp_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_simd_inst_issuer.sv
// Scoreboard bench for simd_inst_issuer: stimulus pushes expected beats/checks, a negedge monitor compares.
// Expected perf-counter values follow SIMD_ISSUE_PERF_EN.
module tb_simd_inst_issuer;
   localparam int N_INST  = 16;
   localparam int INST_BW = 5;
   localparam int DIM     = 2;
   localparam int WBW     = 16;
   localparam int WID_BW  = 4;
`ifdef SIMD_ISSUE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                    clk, rst_n, warp_rdy, warp_ack, inst_rdy, inst_ack, o_last, o_idle;
   logic [WID_BW-1:0]       i_wid, o_wid;
   logic [DIM-1:0][WBW-1:0] i_bofs, i_aofs, o_bofs, o_aofs;
   logic [INST_BW-1:0]      i_n_inst, o_pc;
   logic [31:0]             o_stall_cnt, o_warp_cnt;

   simd_inst_issuer dut (
      .i_clk(clk), .i_rst(rst_n),
      .warp_rdy(warp_rdy), .warp_ack(warp_ack),
      .i_wid(i_wid), .i_bofs(i_bofs), .i_aofs(i_aofs), .i_n_inst(i_n_inst),
      .inst_rdy(inst_rdy), .inst_ack(inst_ack),
      .o_pc(o_pc), .o_wid(o_wid), .o_bofs(o_bofs), .o_aofs(o_aofs),
      .o_last(o_last), .o_idle(o_idle),
      .o_stall_cnt(o_stall_cnt), .o_warp_cnt(o_warp_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [INST_BW-1:0] pc;
      logic [WID_BW-1:0]  wid;
      logic [31:0]        bofs;
      logic [31:0]        aofs;
      logic               last;
   } beat_t;

   typedef struct {
      string       name;
      logic [63:0] act;
      logic [63:0] exp;
   } chk_t;

   beat_t exp_q[$];
   chk_t  chk_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    exp_warps = 0;

   task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: drains queued checks and scores every accepted beat against the scoreboard.
   always @(negedge clk) begin
      chk_t  c;
      beat_t b;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         compare(c.name, c.act, c.exp);
      end
      if (rst_n && inst_rdy && inst_ack) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got pc=%0d wid=%0d, expected no beat", o_pc, o_wid);
         end else begin
            b = exp_q.pop_front();
            compare("beat_pc",   64'(o_pc),   64'(b.pc));
            compare("beat_wid",  64'(o_wid),  64'(b.wid));
            compare("beat_bofs", 64'(o_bofs), 64'(b.bofs));
            compare("beat_aofs", 64'(o_aofs), 64'(b.aofs));
            compare("beat_last", 64'(o_last), 64'(b.last));
            $display("beat pc=%0d wid=%0d bofs=%08h aofs=%08h last=%0b", o_pc, o_wid, o_bofs, o_aofs, o_last);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_q.push_back('{name, act, exp});
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic to_sample();
      @(negedge clk);
   endtask

   task automatic push_warp(input logic [WID_BW-1:0] wid, input int n, input logic [31:0] b, input logic [31:0] a);
      int ne;
      ne = (n > N_INST) ? N_INST : n;
      for (int p = 0; p < ne; p++)
         exp_q.push_back('{INST_BW'(p), wid, b, a, (p == ne - 1)});
      if (ne > 0) exp_warps++;
   endtask

   task automatic drive_warp(input logic [WID_BW-1:0] wid, input int n, input logic [31:0] b, input logic [31:0] a);
      warp_rdy = 1'b1;
      i_wid    = wid;
      i_n_inst = INST_BW'(n);
      i_bofs   = b;
      i_aofs   = a;
   endtask

   task automatic accept(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         to_sample();
         if (warp_ack) ok = 1'b1;
         to_drive();
         if (ok) break;
      end
      chk(name, 64'(ok), 64'd1);
      $display("warp accepted wid=%0d n_inst=%0d", i_wid, i_n_inst);
   endtask

   task automatic wait_idle(input string name, input int bound);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         to_sample();
         if (o_idle) ok = 1'b1;
         to_drive();
         if (ok) break;
      end
      chk(name, 64'(ok), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_inst_rdy"}, 64'(inst_rdy), 64'd0);
      chk({tag, "_pc"},       64'(o_pc),     64'd0);
      chk({tag, "_wid"},      64'(o_wid),    64'd0);
      chk({tag, "_bofs"},     64'(o_bofs),   64'd0);
      chk({tag, "_aofs"},     64'(o_aofs),   64'd0);
      chk({tag, "_last"},     64'(o_last),   64'd0);
      chk({tag, "_idle"},     64'(o_idle),   64'd1);
      chk({tag, "_stall"},    64'(o_stall_cnt), 64'd0);
      chk({tag, "_warps"},    64'(o_warp_cnt),  64'd0);
   endtask

   initial begin
      rst_n = 1'b0; warp_rdy = 1'b0; inst_ack = 1'b0;
      i_wid = '0; i_bofs = '0; i_aofs = '0; i_n_inst = '0;

      to_sample();
      chk_reset_outputs("rst");
      chk("rst_warp_ack", 64'(warp_ack), 64'd0);
      to_drive();
      rst_n = 1'b1;
      to_drive();

      // Single warp, 3 beats, ack held high
      inst_ack = 1'b1;
      push_warp(4'd5, 3, 32'h0011_0022, 32'h0033_0044);
      drive_warp(4'd5, 3, 32'h0011_0022, 32'h0033_0044);
      to_sample();
      chk("t1_warp_ack", 64'(warp_ack), 64'd1);
      chk("t1_no_early_beat", 64'(inst_rdy), 64'd0);
      to_drive();
      warp_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         to_sample();
         chk("t1_consecutive_rdy", 64'(inst_rdy), 64'd1);
         to_drive();
      end
      to_sample();
      chk("t1_idle_after", 64'(o_idle), 64'd1);
      chk("t1_rdy_after", 64'(inst_rdy), 64'd0);
      to_drive();

      // Backpressure: 4 stalled cycles at pc=0
      inst_ack = 1'b0;
      push_warp(4'd3, 2, 32'h1111_2222, 32'h3333_4444);
      drive_warp(4'd3, 2, 32'h1111_2222, 32'h3333_4444);
      accept("t2_accept");
      warp_rdy = 1'b0;
      i_bofs = '0;
      for (int k = 0; k < 4; k++) begin
         to_sample();
         chk("t2_hold_rdy",  64'(inst_rdy), 64'd1);
         chk("t2_hold_pc",   64'(o_pc),     64'd0);
         chk("t2_hold_wid",  64'(o_wid),    64'd3);
         chk("t2_hold_bofs", 64'(o_bofs),   64'h1111_2222);
         chk("t2_hold_aofs", 64'(o_aofs),   64'h3333_4444);
         to_drive();
      end
      inst_ack = 1'b1;
      to_sample();
      chk("t2_stall_cnt", 64'(o_stall_cnt), PERF ? 64'd4 : 64'd0);
      to_drive();
      wait_idle("t2_done", 10);

      // Back-to-back warps with no bubble
      push_warp(4'd1, 2, 32'hAAAA_0001, 32'hBBBB_0001);
      drive_warp(4'd1, 2, 32'hAAAA_0001, 32'hBBBB_0001);
      to_sample();
      chk("t3_ack_first", 64'(warp_ack), 64'd1);
      to_drive();
      push_warp(4'd2, 2, 32'hAAAA_0002, 32'hBBBB_0002);
      drive_warp(4'd2, 2, 32'hAAAA_0002, 32'hBBBB_0002);
      to_sample();
      chk("t3_no_ack_mid", 64'(warp_ack), 64'd0);
      to_drive();
      to_sample();
      chk("t3_ack_on_last", 64'(warp_ack), 64'd1);
      chk("t3_last_flag", 64'(o_last), 64'd1);
      to_drive();
      warp_rdy = 1'b0;
      to_sample();
      chk("t3_no_bubble", 64'(inst_rdy), 64'd1);
      chk("t3_new_wid", 64'(o_wid), 64'd2);
      to_drive();
      to_sample();
      to_drive();
      to_sample();
      chk("t3_idle_after", 64'(o_idle), 64'd1);
      to_drive();

      // Zero-length warp is consumed and dropped
      push_warp(4'd7, 0, 32'h7777_7777, 32'h7777_7777);
      drive_warp(4'd7, 0, 32'h7777_7777, 32'h7777_7777);
      to_sample();
      chk("t4_zero_ack", 64'(warp_ack), 64'd1);
      to_drive();
      warp_rdy = 1'b0;
      to_sample();
      chk("t4_zero_no_rdy", 64'(inst_rdy), 64'd0);
      chk("t4_zero_idle", 64'(o_idle), 64'd1);
      to_drive();

      // Oversized length clamps to N_INST
      push_warp(4'd9, 20, 32'h0909_0909, 32'h9090_9090);
      drive_warp(4'd9, 20, 32'h0909_0909, 32'h9090_9090);
      accept("t4_clamp_accept");
      warp_rdy = 1'b0;
      wait_idle("t4_clamp_done", 40);

      // Length change after acceptance is ignored
      push_warp(4'd4, 4, 32'h0004_0004, 32'h0040_0040);
      drive_warp(4'd4, 4, 32'h0004_0004, 32'h0040_0040);
      accept("t5_accept");
      warp_rdy = 1'b0;
      i_n_inst = 5'd1;
      wait_idle("t5_done", 20);
      to_sample();
      chk("t5_warp_cnt", 64'(o_warp_cnt), PERF ? 64'(exp_warps) : 64'd0);
      to_drive();

      // Async reset while pc=2 is presented; only pc 0 and 1 are consumed
      exp_q.push_back('{5'd0, 4'd6, 32'h0606_0606, 32'h6060_6060, 1'b0});
      exp_q.push_back('{5'd1, 4'd6, 32'h0606_0606, 32'h6060_6060, 1'b0});
      drive_warp(4'd6, 4, 32'h0606_0606, 32'h6060_6060);
      accept("t6_accept");
      warp_rdy = 1'b0;
      to_sample();
      to_drive();
      to_sample();
      to_drive();
      chk("t6_pc_before_reset", 64'(o_pc), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6_async");
      exp_warps = 0;
      to_drive();
      rst_n = 1'b1;
      push_warp(4'd8, 2, 32'h0808_0808, 32'h8080_8080);
      drive_warp(4'd8, 2, 32'h0808_0808, 32'h8080_8080);
      accept("t6_restart_accept");
      warp_rdy = 1'b0;
      to_sample();
      chk("t6_restart_pc", 64'(o_pc), 64'd0);
      to_drive();
      wait_idle("t6_done", 10);

      to_sample();
      chk("final_warp_cnt", 64'(o_warp_cnt), PERF ? 64'(exp_warps) : 64'd0);
      chk("final_stall_cnt", 64'(o_stall_cnt), 64'd0);
      chk("leftover_beats", 64'(exp_q.size()), 64'd0);
      repeat (3) to_drive();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
